// File: rtl/lane_vrf_write_sink.sv
// Receiving end of the lane VRF write channel: masked word writes, per-instruction commit counters, forwarding read port.
// Optional even-parity storage per byte is enabled by defining VRF_WRITE_PARITY_EN.
module lane_vrf_write_sink #(
  parameter int REG_NUM     = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          vrfWriteRequest_valid,
  output logic                          vrfWriteRequest_ready,
  input  logic [$clog2(REG_NUM)-1:0]    vrfWriteRequest_bits_vd,
  input  logic                          vrfWriteRequest_bits_offset,
  input  logic [DATA_WIDTH/8-1:0]       vrfWriteRequest_bits_mask,
  input  logic [DATA_WIDTH-1:0]         vrfWriteRequest_bits_data,
  input  logic                          vrfWriteRequest_bits_last,
  input  logic [INDEX_WIDTH-1:0]        vrfWriteRequest_bits_instructionIndex,
  input  logic                          bankBusy,
  input  logic                          readRequest_valid,
  input  logic [$clog2(REG_NUM)-1:0]    readRequest_bits_vs,
  input  logic                          readRequest_bits_offset,
  output logic                          readResult_valid,
  output logic [DATA_WIDTH-1:0]         readResult_bits_data,
`ifdef VRF_WRITE_PARITY_EN
  input  logic                          parityInjectEn,
  output logic                          readResult_bits_parityError,
`endif
  output logic                          instructionFinished_valid,
  output logic [INDEX_WIDTH-1:0]        instructionFinished_bits_index,
  output logic [COUNT_WIDTH-1:0]        instructionFinished_bits_count,
  output logic [2**INDEX_WIDTH-1:0]     instructionBusy
);

  localparam int VW    = $clog2(REG_NUM);
  localparam int AW    = VW + 1;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int NI    = 2 ** INDEX_WIDTH;
  localparam int WORDS = 2 * REG_NUM;
  localparam logic [COUNT_WIDTH-1:0] CMAX = {COUNT_WIDTH{1'b1}};

  logic                   w_accept;
  logic                   w_commit;

  logic                   r_s1_valid;
  logic [AW-1:0]          r_s1_addr;
  logic [NB-1:0]          r_s1_mask;
  logic [DATA_WIDTH-1:0]  r_s1_data;
  logic                   r_s1_last;
  logic [INDEX_WIDTH-1:0] r_s1_idx;

  logic [DATA_WIDTH-1:0]  r_mem [WORDS];
  logic [COUNT_WIDTH-1:0] r_cnt [NI];

  logic [COUNT_WIDTH-1:0] w_cnt_cur;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;
  logic [NI-1:0]          w_busy;

  logic [AW-1:0]          w_rd_addr;
  logic                   w_fwd;
  logic [DATA_WIDTH-1:0]  w_rd_word;
  logic                   r_rd_valid;
  logic [DATA_WIDTH-1:0]  r_rd_data;

  assign vrfWriteRequest_ready = ~reset & ~bankBusy;
  assign w_accept = vrfWriteRequest_valid & vrfWriteRequest_ready;
  // Reset in the commit cycle drops the pending write entirely.
  assign w_commit = r_s1_valid & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
    if (w_accept) begin
      r_s1_addr <= {vrfWriteRequest_bits_vd, vrfWriteRequest_bits_offset};
      r_s1_mask <= vrfWriteRequest_bits_mask;
      r_s1_data <= vrfWriteRequest_bits_data;
      r_s1_last <= vrfWriteRequest_bits_last;
      r_s1_idx  <= vrfWriteRequest_bits_instructionIndex;
    end
  end

  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int k = 0; k < NB; k++) begin
        if (r_s1_mask[k]) begin
          r_mem[r_s1_addr][k*8 +: 8] <= r_s1_data[k*8 +: 8];
        end
      end
    end
  end

  assign w_cnt_cur = r_cnt[r_s1_idx];
  assign w_cnt_inc = (w_cnt_cur == CMAX) ? CMAX : w_cnt_cur + COUNT_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_commit) begin
      r_cnt[r_s1_idx] <= r_s1_last ? '0 : w_cnt_inc;
    end
  end

  assign instructionFinished_valid      = w_commit & r_s1_last;
  assign instructionFinished_bits_index = instructionFinished_valid ? r_s1_idx : '0;
  assign instructionFinished_bits_count = instructionFinished_valid ? w_cnt_inc : '0;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NI; i++) begin
      w_busy[i] = |r_cnt[i];
    end
  end
  assign instructionBusy = reset ? '0 : w_busy;

  // Read sees the pending S1 bytes so that it never lags a write accepted earlier.
  assign w_rd_addr = {readRequest_bits_vs, readRequest_bits_offset};
  assign w_fwd     = r_s1_valid & (r_s1_addr == w_rd_addr);

  always_comb begin
    w_rd_word = r_mem[w_rd_addr];
    for (int k = 0; k < NB; k++) begin
      if (w_fwd && r_s1_mask[k]) begin
        w_rd_word[k*8 +: 8] = r_s1_data[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= readRequest_valid;
      if (readRequest_valid) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign readResult_valid     = r_rd_valid & ~reset;
  assign readResult_bits_data = reset ? '0 : r_rd_data;

`ifdef VRF_WRITE_PARITY_EN
  logic [NB-1:0] r_par [WORDS];
  logic          w_rd_perr;
  logic          r_rd_perr;

  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int k = 0; k < NB; k++) begin
        if (r_s1_mask[k]) begin
          r_par[r_s1_addr][k] <= (^r_s1_data[k*8 +: 8]) ^ parityInjectEn;
        end
      end
    end
  end

  // Forwarded bytes carry freshly computed parity, so only array bytes are checked.
  always_comb begin
    w_rd_perr = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (!(w_fwd && r_s1_mask[k])) begin
        w_rd_perr = w_rd_perr | ((^r_mem[w_rd_addr][k*8 +: 8]) ^ r_par[w_rd_addr][k]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_perr <= 1'b0;
    end else if (readRequest_valid) begin
      r_rd_perr <= w_rd_perr;
    end
  end

  assign readResult_bits_parityError = r_rd_perr & r_rd_valid & ~reset;
`endif

endmodule

// File: tb/tb_lane_vrf_write_sink.sv
// Directed bench for lane_vrf_write_sink: writes, masks, forwarding, counters, backpressure, reset.
// Connects the parity ports when VRF_WRITE_PARITY_EN is defined.
module tb_lane_vrf_write_sink;

  logic        clock = 1'b0;
  logic        reset;
  logic        vrfWriteRequest_valid;
  logic        vrfWriteRequest_ready;
  logic [4:0]  vrfWriteRequest_bits_vd;
  logic        vrfWriteRequest_bits_offset;
  logic [3:0]  vrfWriteRequest_bits_mask;
  logic [31:0] vrfWriteRequest_bits_data;
  logic        vrfWriteRequest_bits_last;
  logic [2:0]  vrfWriteRequest_bits_instructionIndex;
  logic        bankBusy;
  logic        readRequest_valid;
  logic [4:0]  readRequest_bits_vs;
  logic        readRequest_bits_offset;
  logic        readResult_valid;
  logic [31:0] readResult_bits_data;
  logic        instructionFinished_valid;
  logic [2:0]  instructionFinished_bits_index;
  logic [7:0]  instructionFinished_bits_count;
  logic [7:0]  instructionBusy;
`ifdef VRF_WRITE_PARITY_EN
  logic        parityInjectEn = 1'b0;
  logic        readResult_bits_parityError;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  lane_vrf_write_sink dut (
    .clock                                (clock),
    .reset                                (reset),
    .vrfWriteRequest_valid                (vrfWriteRequest_valid),
    .vrfWriteRequest_ready                (vrfWriteRequest_ready),
    .vrfWriteRequest_bits_vd              (vrfWriteRequest_bits_vd),
    .vrfWriteRequest_bits_offset          (vrfWriteRequest_bits_offset),
    .vrfWriteRequest_bits_mask            (vrfWriteRequest_bits_mask),
    .vrfWriteRequest_bits_data            (vrfWriteRequest_bits_data),
    .vrfWriteRequest_bits_last            (vrfWriteRequest_bits_last),
    .vrfWriteRequest_bits_instructionIndex(vrfWriteRequest_bits_instructionIndex),
    .bankBusy                             (bankBusy),
    .readRequest_valid                    (readRequest_valid),
    .readRequest_bits_vs                  (readRequest_bits_vs),
    .readRequest_bits_offset              (readRequest_bits_offset),
    .readResult_valid                     (readResult_valid),
    .readResult_bits_data                 (readResult_bits_data),
`ifdef VRF_WRITE_PARITY_EN
    .parityInjectEn                       (parityInjectEn),
    .readResult_bits_parityError          (readResult_bits_parityError),
`endif
    .instructionFinished_valid            (instructionFinished_valid),
    .instructionFinished_bits_index       (instructionFinished_bits_index),
    .instructionFinished_bits_count       (instructionFinished_bits_count),
    .instructionBusy                      (instructionBusy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wr(input logic [4:0] vd, input logic off, input logic [3:0] mask,
                          input logic [31:0] data, input logic last, input logic [2:0] idx);
    vrfWriteRequest_valid                = 1'b1;
    vrfWriteRequest_bits_vd              = vd;
    vrfWriteRequest_bits_offset          = off;
    vrfWriteRequest_bits_mask            = mask;
    vrfWriteRequest_bits_data            = data;
    vrfWriteRequest_bits_last            = last;
    vrfWriteRequest_bits_instructionIndex = idx;
  endtask

  task automatic idle_wr;
    vrfWriteRequest_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] vs, input logic off);
    readRequest_valid       = 1'b1;
    readRequest_bits_vs     = vs;
    readRequest_bits_offset = off;
  endtask

  task automatic rd_off;
    readRequest_valid = 1'b0;
  endtask

  task automatic check_fin(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] cnt);
    check_val({tag, "_valid"}, instructionFinished_valid, v);
    check_val({tag, "_index"}, instructionFinished_bits_index, idx);
    check_val({tag, "_count"}, instructionFinished_bits_count, cnt);
  endtask

  initial begin
    reset = 1'b1;
    bankBusy = 1'b0;
    readRequest_valid = 1'b0;
    readRequest_bits_vs = 5'd0;
    readRequest_bits_offset = 1'b0;
    drive_wr(5'd0, 1'b0, 4'h0, 32'h0, 1'b0, 3'd0);
    idle_wr();
    cyc();
    cyc();

    // reset state
    check_val("rst_ready", vrfWriteRequest_ready, 1'b0);
    check_val("rst_rd_valid", readResult_valid, 1'b0);
    check_val("rst_rd_data", readResult_bits_data, 32'h0);
    check_fin("rst_fin", 1'b0, 3'd0, 8'd0);
    check_val("rst_busy", instructionBusy, 8'h00);
    reset = 1'b0;
    #1;
    check_val("ready_after_rst", vrfWriteRequest_ready, 1'b1);

    // full write, read two cycles later
    drive_wr(5'd3, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 3'd0);
    cyc();
    idle_wr();
    check_fin("full_fin", 1'b1, 3'd0, 8'd1);
    cyc();
    rd(5'd3, 1'b1);
    cyc();
    rd_off();
    check_val("full_rd_valid", readResult_valid, 1'b1);
    check_val("full_rd_data", readResult_bits_data, 32'hDEADBEEF);
    cyc();
    check_val("full_rd_valid_drop", readResult_valid, 1'b0);

    // partial mask over a preloaded word, back-to-back
    drive_wr(5'd4, 1'b0, 4'hF, 32'h11223344, 1'b0, 3'd1);
    cyc();
    drive_wr(5'd4, 1'b0, 4'b0101, 32'hAABBCCDD, 1'b1, 3'd1);
    cyc();
    idle_wr();
    check_fin("part_fin", 1'b1, 3'd1, 8'd2);
    rd(5'd4, 1'b0);
    cyc();
    rd_off();
    check_val("part_fwd_data", readResult_bits_data, 32'h11BB33DD);
    rd(5'd4, 1'b0);
    cyc();
    rd_off();
    check_val("part_array_data", readResult_bits_data, 32'h11BB33DD);
    check_val("part_busy_clear", instructionBusy, 8'h00);

    // forwarding: W1 accepted at N-1, W2 accepted at N alongside a read
    drive_wr(5'd5, 1'b0, 4'hF, 32'h55555555, 1'b0, 3'd3);
    cyc();
    idle_wr();
    cyc();
    drive_wr(5'd5, 1'b0, 4'hF, 32'h12345678, 1'b0, 3'd3);
    cyc();
    drive_wr(5'd5, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1, 3'd3);
    rd(5'd5, 1'b0);
    cyc();
    idle_wr();
    check_val("fwd_excl_new", readResult_bits_data, 32'h12345678);
    check_fin("fwd_fin", 1'b1, 3'd3, 8'd3);
    cyc();
    rd_off();
    check_val("fwd_incl_pending", readResult_bits_data, 32'hCAFEF00D);

    // counting: 4 writes on idx 2, last on the 4th
    for (int i = 0; i < 4; i++) begin
      drive_wr(5'd10, i[0], 4'hF, 32'(i), (i == 3), 3'd2);
      cyc();
      if (i == 1) check_val("cnt_busy_set", instructionBusy[2], 1'b1);
    end
    idle_wr();
    check_fin("cnt_fin", 1'b1, 3'd2, 8'd4);
    check_val("cnt_busy_before", instructionBusy[2], 1'b1);
    cyc();
    check_val("cnt_fin_pulse_end", instructionFinished_valid, 1'b0);
    check_val("cnt_busy_after", instructionBusy[2], 1'b0);

    // saturation: 256 mask-0 writes on idx 4 (last on the final one) to vd3/off1
    for (int i = 0; i < 256; i++) begin
      drive_wr(5'd3, 1'b1, 4'h0, 32'hFFFFFFFF, (i == 255), 3'd4);
      cyc();
    end
    idle_wr();
    check_val("sat_busy", instructionBusy[4], 1'b1);
    check_fin("sat_fin", 1'b1, 3'd4, 8'd255);
    rd(5'd3, 1'b1);
    cyc();
    rd_off();
    check_val("mask0_no_change", readResult_bits_data, 32'hDEADBEEF);
    check_val("sat_busy_clear", instructionBusy[4], 1'b0);

    // backpressure: bankBusy for 3 cycles with valid held
    bankBusy = 1'b1;
    drive_wr(5'd6, 1'b1, 4'hF, 32'hA5A5A5A5, 1'b1, 3'd5);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bp_ready_low", vrfWriteRequest_ready, 1'b0);
      cyc();
      check_val("bp_no_commit", instructionFinished_valid, 1'b0);
    end
    bankBusy = 1'b0;
    #1;
    check_val("bp_ready_high", vrfWriteRequest_ready, 1'b1);
    cyc();
    idle_wr();
    bankBusy = 1'b1;
    #1;
    check_fin("bp_commit_under_busy", 1'b1, 3'd5, 8'd1);
    check_val("bp_ready_blocked", vrfWriteRequest_ready, 1'b0);
    cyc();
    bankBusy = 1'b0;
    rd(5'd6, 1'b1);
    cyc();
    rd_off();
    check_val("bp_rd_data", readResult_bits_data, 32'hA5A5A5A5);

    // reset mid-stream
    drive_wr(5'd7, 1'b0, 4'hF, 32'h01010101, 1'b0, 3'd6);
    cyc();
    idle_wr();
    cyc();
    check_val("rs_busy_pre", instructionBusy[6], 1'b1);
    drive_wr(5'd7, 1'b0, 4'hF, 32'hFFFFFFFF, 1'b1, 3'd6);
    rd(5'd7, 1'b0);
    cyc();
    idle_wr();
    rd_off();
    reset = 1'b1;
    #1;
    check_fin("rs_fin", 1'b0, 3'd0, 8'd0);
    check_val("rs_ready", vrfWriteRequest_ready, 1'b0);
    check_val("rs_rd_valid", readResult_valid, 1'b0);
    check_val("rs_rd_data", readResult_bits_data, 32'h0);
    check_val("rs_busy", instructionBusy, 8'h00);
    cyc();
    reset = 1'b0;
    #1;
    check_val("rs_busy_post", instructionBusy, 8'h00);
    rd(5'd7, 1'b0);
    cyc();
    rd_off();
    check_val("rs_dropped_write", readResult_bits_data, 32'h01010101);
    drive_wr(5'd7, 1'b1, 4'hF, 32'h0, 1'b1, 3'd6);
    cyc();
    idle_wr();
    check_fin("rs_cnt_cleared", 1'b1, 3'd6, 8'd1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_vrf_write_sink.md
Name: lane_vrf_write_sink

Overview:
Receiving end of the lane's VRF write-request channel. It accepts masked 32-bit writes (vd, offset, mask, data, last, instructionIndex) through a valid/ready handshake and commits them into a banked register-file array one cycle later. It also keeps per-instruction commit counters, pulses a completion event on a write flagged last, and serves a 1-cycle-latency read port with forwarding from the pending write. It sits between the lane write stage and the VRF storage; the bench uses it as the VRF model.

Parameters:
REG_NUM, 32, number of vector registers; each register holds 2 words (offset 0/1)
DATA_WIDTH, 32, word width; mask width = DATA_WIDTH/8
INDEX_WIDTH, 3, instructionIndex width; 2**INDEX_WIDTH counters
COUNT_WIDTH, 8, width of each per-instruction commit counter

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
vrfWriteRequest_valid  in  1  write request valid
vrfWriteRequest_ready  out  1  write request accepted when valid&ready
vrfWriteRequest_bits_vd  in  log2(REG_NUM)  destination register
vrfWriteRequest_bits_offset  in  1  word within register
vrfWriteRequest_bits_mask  in  DATA_WIDTH/8  byte enables
vrfWriteRequest_bits_data  in  DATA_WIDTH  write data
vrfWriteRequest_bits_last  in  1  final write of the instruction
vrfWriteRequest_bits_instructionIndex  in  INDEX_WIDTH  owning instruction
bankBusy  in  1  storage unavailable this cycle; blocks acceptance
readRequest_valid  in  1  read request (always accepted)
readRequest_bits_vs  in  log2(REG_NUM)  read register
readRequest_bits_offset  in  1  read word
readResult_valid  out  1  read data valid
readResult_bits_data  out  DATA_WIDTH  read data
instructionFinished_valid  out  1  one-cycle completion pulse
instructionFinished_bits_index  out  INDEX_WIDTH  completed instruction
instructionFinished_bits_count  out  COUNT_WIDTH  writes committed for it, including the last
instructionBusy  out  2**INDEX_WIDTH  bit i = counter i nonzero

Behaviour:
- Clocking/reset: one clock `clock`; `reset` is synchronous, active-high.
- Reset values:
  - vrfWriteRequest_ready=0 while reset is high.
  - readResult_valid=0, readResult_bits_data=0.
  - instructionFinished_valid=0, _index=0, _count=0.
  - instructionBusy=0.
  - All counters 0; pending stage invalid.
  - Array contents are not reset.
- Reset mid-operation: a pending uncommitted write is dropped; an in-flight read result is not produced.
- Ready: vrfWriteRequest_ready = ~reset & ~bankBusy. Purely combinational; does not depend on valid.
- Accept stage: on accept, capture the request into the pending register S1.
- Commit: the cycle after accept, S1 commits. Array word {vd,offset} byte k is replaced by data byte k where mask[k]=1. An accept and a commit may overlap every cycle, giving 1 write/cycle throughput.
- mask=0: no array change, but the write is still counted and may carry last.
- Counters:
  - On commit, counter[idx] increments, saturating at 2**COUNT_WIDTH-1.
  - If last=1, in the commit cycle: instructionFinished_valid=1, index=idx, count=incremented value. counter[idx] is then 0 next cycle.
  - instructionBusy reflects registered counter state.
- Read:
  - readRequest_valid at cycle N gives readResult_valid at N+1.
  - Data = array word, merged bytewise with S1 when S1 is valid at N and targets the same {vs,offset}. The result therefore includes every write accepted at or before cycle N-1 and excludes writes accepted at N.
  - Reads never stall writes or each other.
- Boundaries:
  - bankBusy high with a pending S1: S1 still commits; only new acceptance is blocked.
  - Back-to-back writes to the same address: the later write wins per byte.
  - Two last commits to different indices occur in different cycles; each gives its own pulse.

Optional Feature:
VRF_WRITE_PARITY_EN:
- Defined:
  - Each stored byte keeps an even-parity bit, updated with its byte.
  - Added output readResult_bits_parityError (1 bit) = 1 when any byte of the read word fails parity (forwarded bytes are recomputed and never fail).
  - Added input parityInjectEn (1 bit): when high at commit, the stored parity of written bytes is inverted.
  - Reset value of readResult_bits_parityError = 0.
- Undefined: neither port nor parity storage exists.

Test Plan:
- Full write: vd=3, off=1, mask=4'hF, data=32'hDEADBEEF; read vs=3/off=1 two cycles later -> readResult_bits_data=32'hDEADBEEF at read cycle+1.
- Partial mask: word preloaded to 32'h11223344, then write mask=4'b0101, data=32'hAABBCCDD -> read returns 32'h11BB33DD.
- Forwarding: write accepted at N-1 to vd=5/off=0; read same address at N -> result at N+1 shows new data, although the array commits at N.
- Counting: 4 writes idx=2, last on the 4th -> instructionFinished_valid pulse one cycle after 4th accept, index=2, count=4; instructionBusy[2] goes 1 then 0.
- Backpressure: bankBusy=1 for 3 cycles with valid held -> ready=0, no commits; bankBusy drops -> accept, commit next cycle.
- Reset mid-stream: assert reset the cycle after accepting a write to vd=7 -> that write is not committed, counters 0, all outputs at reset values.
